tsc_param: RTL and testbench

- Parametrised transient-capture engine. Reads samples from the ADC array via a req/rdy handshake and keeps them in a DEPTH-entry ring buffer.
- Detects a programmable threshold crossing, captures POST_SAMPLES further samples, and flags completion to the external device.
- On request, streams the buffer oldest-first over a framed serial line.
- Successor to the fixed 8-bit/32-deep capture block; sits between the ADC array and the external host interface.

---
 rtl/tsc_pkg.sv | 21 ++
 rtl/tsc_serialiser.sv | 68 ++++++
 rtl/tsc_param.sv | 226 ++++++++++++++++++++++
 tb/tb_tsc_param.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tsc_pkg.sv
// Shared state encoding, serial framing constants and frame-length helper for tsc_param.
package tsc_pkg;

    localparam int unsigned STATE_W = 3;
    typedef logic [STATE_W-1:0] state_t;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ARMED = 3'd1;
    localparam logic [2:0] ST_POST  = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_SEND  = 3'd4;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // One start bit, data_w data bits, one stop bit.
    function automatic int unsigned frame_len(input int unsigned data_w);
        return data_w + 32'd2;
    endfunction

endpackage

// File: rtl/tsc_serialiser.sv
// Emits one framed word (start, MSB-first data, stop) on sd per go pulse.
// frame_done_c is high during the stop bit, so a go in that cycle sends the next frame back-to-back.
module tsc_serialiser
    import tsc_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              go,
    input  logic [DATA_W-1:0] word,
    output logic              sd,
    output logic              frame_done_c
);

    localparam int unsigned FRAME_LEN = frame_len(DATA_W);
    localparam int unsigned CNT_W     = $clog2(FRAME_LEN);

    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              busy_q, busy_d;
    logic              sd_q, sd_d;

    assign frame_done_c = busy_q && (bit_cnt_q == CNT_W'(FRAME_LEN - 1));
    assign sd           = sd_q;

    always_comb begin
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        busy_d    = busy_q;
        sd_d      = sd_q;
        if (go) begin
            shift_d   = word;
            bit_cnt_d = '0;
            busy_d    = 1'b1;
            sd_d      = START_BIT;
        end else if (busy_q) begin
            if (frame_done_c) begin
                busy_d    = 1'b0;
                bit_cnt_d = '0;
                sd_d      = STOP_BIT;
            end else begin
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
                if (bit_cnt_q == CNT_W'(DATA_W)) begin
                    sd_d = STOP_BIT;
                end else begin
                    sd_d    = shift_q[DATA_W-1];
                    shift_d = shift_q << 1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
            busy_q    <= 1'b0;
            sd_q      <= STOP_BIT;
        end else begin
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            busy_q    <= busy_d;
            sd_q      <= sd_d;
        end
    end

endmodule

// File: rtl/tsc_param.sv
// Transient-capture engine: ring-buffers ADC samples, triggers on a threshold crossing, streams the buffer serially.
// Define TSC_CHECKSUM_EN to append an XOR checksum frame after the data frames.
module tsc_param
    import tsc_pkg::*;
#(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned DEPTH        = 32,
    parameter int unsigned POST_SAMPLES = 16,
    parameter int unsigned TS_W         = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              sbf,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              trig_pol,
    input  logic              rdy,
    input  logic [DATA_W-1:0] dat,
    output logic              req,
    output logic              rst,
    output logic              trd,
    output logic [TS_W-1:0]   cd,
    output logic              sd,
    output logic              send_done
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned PC_W  = $clog2(POST_SAMPLES) + 1;

    state_t            state_q, state_d;
    logic              req_q, req_d;
    logic              rst_q, rst_d;
    logic              trd_q, trd_d;
    logic              send_done_q, send_done_d;
    logic [TS_W-1:0]   timer_q, timer_d;
    logic [TS_W-1:0]   cd_q, cd_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  frames_left_q, frames_left_d;
    logic [PC_W-1:0]   post_cnt_q, post_cnt_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              accept_c, trig_hit_c, wr_en_c, go_c, frame_done_c;
    logic [DATA_W-1:0] tx_word_c;
    logic [PTR_W-1:0]  oldest_c;

`ifdef TSC_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q, csum_d;
    logic              csum_sent_q, csum_sent_d;
`endif

    assign accept_c   = req_q && rdy;
    assign trig_hit_c = trig_pol ? (dat < trig_level) : (dat > trig_level);
    // A full buffer has count[PTR_W-1:0]==0, making the oldest entry wr_ptr itself.
    assign oldest_c   = wr_ptr_q - count_q[PTR_W-1:0];

    always_comb begin
        state_d       = state_q;
        req_d         = 1'b0;
        rst_d         = 1'b0;
        trd_d         = trd_q;
        send_done_d   = 1'b0;
        timer_d       = timer_q;
        cd_d          = cd_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        frames_left_d = frames_left_q;
        post_cnt_d    = post_cnt_q;
        wr_en_c       = 1'b0;
        go_c          = 1'b0;
        tx_word_c     = mem_q[rd_ptr_q];
`ifdef TSC_CHECKSUM_EN
        csum_d        = csum_q;
        csum_sent_d   = csum_sent_q;
`endif

        if ((state_q == ST_ARMED) || (state_q == ST_POST)) begin
            timer_d = timer_q + TS_W'(1);
        end

        if (accept_c) begin
            wr_en_c  = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (count_q != CNT_W'(DEPTH)) begin
                count_d = count_q + CNT_W'(1);
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_ARMED;
                    timer_d  = '0;
                    wr_ptr_d = '0;
                    count_d  = '0;
                    trd_d    = 1'b0;
                    rst_d    = 1'b1;
                end
            end
            ST_ARMED: begin
                if (accept_c && trig_hit_c) begin
                    cd_d       = timer_q;
                    post_cnt_d = '0;
                    state_d    = ST_POST;
                end
            end
            ST_POST: begin
                if (accept_c) begin
                    post_cnt_d = post_cnt_q + PC_W'(1);
                    if (post_cnt_q == PC_W'(POST_SAMPLES - 1)) begin
                        state_d = ST_DONE;
                        trd_d   = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (sbf) begin
                    state_d       = ST_SEND;
                    go_c          = 1'b1;
                    tx_word_c     = mem_q[oldest_c];
                    rd_ptr_d      = oldest_c + PTR_W'(1);
                    frames_left_d = count_q - CNT_W'(1);
`ifdef TSC_CHECKSUM_EN
                    csum_d        = mem_q[oldest_c];
                    csum_sent_d   = 1'b0;
`endif
                end
            end
            ST_SEND: begin
                // frames_left counts frames still to start after the one on the line.
                if (frame_done_c) begin
                    if (frames_left_q != '0) begin
                        go_c          = 1'b1;
                        tx_word_c     = mem_q[rd_ptr_q];
                        rd_ptr_d      = rd_ptr_q + PTR_W'(1);
                        frames_left_d = frames_left_q - CNT_W'(1);
`ifdef TSC_CHECKSUM_EN
                        csum_d        = csum_q ^ mem_q[rd_ptr_q];
`endif
                    end
`ifdef TSC_CHECKSUM_EN
                    else if (!csum_sent_q) begin
                        go_c        = 1'b1;
                        tx_word_c   = csum_q;
                        csum_sent_d = 1'b1;
                    end
`endif
                    else begin
                        state_d     = ST_IDLE;
                        send_done_d = 1'b1;
                        trd_d       = 1'b0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        req_d = (state_d == ST_ARMED) || (state_d == ST_POST);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            req_q         <= 1'b0;
            rst_q         <= 1'b1;
            trd_q         <= 1'b0;
            send_done_q   <= 1'b0;
            timer_q       <= '0;
            cd_q          <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            frames_left_q <= '0;
            post_cnt_q    <= '0;
`ifdef TSC_CHECKSUM_EN
            csum_q        <= '0;
            csum_sent_q   <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            req_q         <= req_d;
            rst_q         <= rst_d;
            trd_q         <= trd_d;
            send_done_q   <= send_done_d;
            timer_q       <= timer_d;
            cd_q          <= cd_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            frames_left_q <= frames_left_d;
            post_cnt_q    <= post_cnt_d;
`ifdef TSC_CHECKSUM_EN
            csum_q        <= csum_d;
            csum_sent_q   <= csum_sent_d;
`endif
        end
    end

    // Sample storage survives reset.
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem_q[wr_ptr_q] <= dat;
        end
    end

    tsc_serialiser #(
        .DATA_W(DATA_W)
    ) u_ser (
        .clk         (clk),
        .reset       (reset),
        .go          (go_c),
        .word        (tx_word_c),
        .sd          (sd),
        .frame_done_c(frame_done_c)
    );

    assign req       = req_q;
    assign rst       = rst_q;
    assign trd       = trd_q;
    assign cd        = cd_q;
    assign send_done = send_done_q;

endmodule

// File: tb/tb_tsc_param.sv
// Directed self-checking bench for tsc_param (8-bit, 32-deep, 16 post samples).
module tb_tsc_param;

    logic        clk = 1'b0;
    logic        reset, start, sbf, trig_pol, rdy;
    logic [7:0]  trig_level, dat;
    logic        req, rst, trd, sd, send_done;
    logic [31:0] cd;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    tsc_param #(
        .DATA_W(8), .DEPTH(32), .POST_SAMPLES(16), .TS_W(32)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .sbf(sbf),
        .trig_level(trig_level), .trig_pol(trig_pol), .rdy(rdy), .dat(dat),
        .req(req), .rst(rst), .trd(trd), .cd(cd), .sd(sd), .send_done(send_done)
    );

    task automatic feed(input logic [7:0] v);
        dat = v;
        rdy = 1'b1;
        @(negedge clk);
    endtask

    task automatic arm();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Request a send and decode every frame against exp_q (plus checksum when enabled).
    task automatic do_send(input string name);
        logic [9:0] frame, want;
        logic [7:0] x;
        int nf, early;
        x = 8'h00;
        early = 0;
        foreach (exp_q[i]) x ^= exp_q[i];
`ifdef TSC_CHECKSUM_EN
        exp_q.push_back(x);
`endif
        n_cmp++;
        if (sd !== 1'b1) begin n_err++; $display("FAIL %s_idle_sd: got %b expected 1", name, sd); end
        sbf = 1'b1;
        @(negedge clk);
        sbf = 1'b0;
        nf = exp_q.size();
        for (int f = 0; f < nf; f++) begin
            frame = '0;
            for (int b = 0; b < 10; b++) begin
                frame = {frame[8:0], sd};
                if (send_done !== 1'b0) early++;
                @(negedge clk);
            end
            want = {1'b0, exp_q[f], 1'b1};
            n_cmp++;
            if (frame !== want) begin
                n_err++;
                $display("FAIL %s_frame%0d: got %b expected %b", name, f, frame, want);
            end
        end
        n_cmp++;
        if (early !== 0) begin n_err++; $display("FAIL %s_early_done: got %0d early cycles expected 0", name, early); end
        n_cmp++;
        if (send_done !== 1'b1) begin n_err++; $display("FAIL %s_send_done: got %b expected 1", name, send_done); end
        n_cmp++;
        if (trd !== 1'b0) begin n_err++; $display("FAIL %s_trd_clr: got %b expected 0", name, trd); end
        @(negedge clk);
        n_cmp++;
        if (send_done !== 1'b0 || sd !== 1'b1) begin
            n_err++;
            $display("FAIL %s_after: got send_done=%b sd=%b expected 0/1", name, send_done, sd);
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; sbf = 1'b0; rdy = 1'b0; dat = 8'h00;
        trig_level = 8'hD5; trig_pol = 1'b0;
        #1 reset = 1'b1;
        #2;
        n_cmp++;
        if ({req, rst, trd, sd, send_done} !== 5'b01010 || cd !== 32'd0) begin
            n_err++;
            $display("FAIL reset_vals: got req=%b rst=%b trd=%b sd=%b sdn=%b cd=%0d expected 0,1,0,1,0,0",
                     req, rst, trd, sd, send_done, cd);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (rst !== 1'b0) begin n_err++; $display("FAIL reset_rst_release: got %b expected 0", rst); end
        arm();
        feed(8'h01);
        feed(8'h02);
        n_cmp++;
        if (req !== 1'b1) begin n_err++; $display("FAIL armed_req: got %b expected 1", req); end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if (req !== 1'b0 || rst !== 1'b1) begin
            n_err++;
            $display("FAIL reset_mid_armed: got req=%b rst=%b expected 0/1", req, rst);
        end
        rdy = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (rst !== 1'b0 || req !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_armed_release: got rst=%b req=%b expected 0/0", rst, req);
        end
    endtask

    task automatic test_ramp_capture();
        trig_level = 8'hD5; trig_pol = 1'b0;
        arm();
        n_cmp++;
        if (rst !== 1'b1 || req !== 1'b1) begin
            n_err++;
            $display("FAIL ramp_arm: got rst=%b req=%b expected 1/1", rst, req);
        end
        for (int i = 0; i < 64; i++) feed(8'(i));
        feed(8'hD6);
        n_cmp++;
        if (cd !== 32'd64) begin n_err++; $display("FAIL ramp_cd: got %0d expected 64", cd); end
        for (int i = 0; i < 15; i++) feed(8'h10 + 8'(i));
        n_cmp++;
        if (trd !== 1'b0 || req !== 1'b1) begin
            n_err++;
            $display("FAIL ramp_post15: got trd=%b req=%b expected 0/1", trd, req);
        end
        feed(8'h1F);
        rdy = 1'b0;
        n_cmp++;
        if (trd !== 1'b1 || req !== 1'b0 || cd !== 32'd64) begin
            n_err++;
            $display("FAIL ramp_done: got trd=%b req=%b cd=%0d expected 1/0/64", trd, req, cd);
        end
        for (int i = 8'h31; i <= 8'h3F; i++) exp_q.push_back(8'(i));
        exp_q.push_back(8'hD6);
        for (int i = 0; i < 16; i++) exp_q.push_back(8'h10 + 8'(i));
        do_send("ramp");
    endtask

    task automatic test_equality_pol();
        trig_level = 8'hD5; trig_pol = 1'b0;
        arm();
        feed(8'hD5);
        trig_pol = 1'b1;
        feed(8'hD5);
        n_cmp++;
        if (cd !== 32'd64 || req !== 1'b1) begin
            n_err++;
            $display("FAIL equal_no_trig: got cd=%0d req=%b expected 64/1", cd, req);
        end
        feed(8'hD4);
        n_cmp++;
        if (cd !== 32'd2) begin n_err++; $display("FAIL pol_low_cd: got %0d expected 2", cd); end
        for (int i = 0; i < 16; i++) feed(8'h80 + 8'(i));
        rdy = 1'b0;
        n_cmp++;
        if (trd !== 1'b1) begin n_err++; $display("FAIL pol_low_trd: got %b expected 1", trd); end
        exp_q.push_back(8'hD5);
        exp_q.push_back(8'hD5);
        exp_q.push_back(8'hD4);
        for (int i = 0; i < 16; i++) exp_q.push_back(8'h80 + 8'(i));
        do_send("pol");
    endtask

    task automatic test_first_sample();
        trig_level = 8'hD5; trig_pol = 1'b0;
        arm();
        feed(8'hFF);
        n_cmp++;
        if (cd !== 32'd0) begin n_err++; $display("FAIL first_cd: got %0d expected 0", cd); end
        for (int i = 0; i < 16; i++) feed(8'(i));
        rdy = 1'b0;
        exp_q.push_back(8'hFF);
        for (int i = 0; i < 16; i++) exp_q.push_back(8'(i));
        do_send("first");
    endtask

    task automatic test_gaps_and_ignores();
        trig_level = 8'hD5; trig_pol = 1'b0;
        start = 1'b1; sbf = 1'b1;
        @(negedge clk);
        start = 1'b0; sbf = 1'b0;
        n_cmp++;
        if (rst !== 1'b1 || req !== 1'b1 || sd !== 1'b1) begin
            n_err++;
            $display("FAIL start_wins: got rst=%b req=%b sd=%b expected 1/1/1", rst, req, sd);
        end
        feed(8'h01);
        rdy = 1'b0;
        repeat (3) @(negedge clk);
        feed(8'hE0);
        n_cmp++;
        if (cd !== 32'd4) begin n_err++; $display("FAIL gap_cd: got %0d expected 4", cd); end
        for (int i = 0; i < 16; i++) begin
            feed(8'h40 + 8'(i));
            rdy = 1'b0;
            sbf = (i == 5);
            @(negedge clk);
            sbf = 1'b0;
            if (i == 14) begin
                n_cmp++;
                if (trd !== 1'b0 || req !== 1'b1 || sd !== 1'b1) begin
                    n_err++;
                    $display("FAIL gap_post15: got trd=%b req=%b sd=%b expected 0/1/1", trd, req, sd);
                end
            end
        end
        n_cmp++;
        if (trd !== 1'b1 || req !== 1'b0) begin
            n_err++;
            $display("FAIL gap_done: got trd=%b req=%b expected 1/0", trd, req);
        end
        start = 1'b1; rdy = 1'b1; dat = 8'h55;
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if (rst !== 1'b0 || trd !== 1'b1 || req !== 1'b0) begin
            n_err++;
            $display("FAIL done_start_ign: got rst=%b trd=%b req=%b expected 0/1/0", rst, trd, req);
        end
        @(negedge clk);
        rdy = 1'b0;
        exp_q.push_back(8'h01);
        exp_q.push_back(8'hE0);
        for (int i = 0; i < 16; i++) exp_q.push_back(8'h40 + 8'(i));
        do_send("gaps");
        sbf = 1'b1;
        @(negedge clk);
        sbf = 1'b0;
        n_cmp++;
        if (sd !== 1'b1) begin n_err++; $display("FAIL idle_sbf_ign: got sd=%b expected 1", sd); end
        @(negedge clk);
        n_cmp++;
        if (sd !== 1'b1 || send_done !== 1'b0) begin
            n_err++;
            $display("FAIL idle_sbf_ign2: got sd=%b sdn=%b expected 1/0", sd, send_done);
        end
    endtask

    task automatic test_checksum();
        trig_level = 8'hFE; trig_pol = 1'b0;
        arm();
        feed(8'h0F);
        feed(8'hF0);
        feed(8'hFF);
        n_cmp++;
        if (cd !== 32'd2) begin n_err++; $display("FAIL csum_cd: got %0d expected 2", cd); end
        for (int i = 0; i < 16; i++) feed(8'h5A);
        rdy = 1'b0;
        exp_q.push_back(8'h0F);
        exp_q.push_back(8'hF0);
        exp_q.push_back(8'hFF);
        for (int i = 0; i < 16; i++) exp_q.push_back(8'h5A);
        do_send("csum");
    endtask

    task automatic test_reset_mid_send();
        trig_level = 8'hD5; trig_pol = 1'b0;
        arm();
        feed(8'h00);
        feed(8'hFF);
        for (int i = 0; i < 16; i++) feed(8'h20 + 8'(i));
        rdy = 1'b0;
        n_cmp++;
        if (trd !== 1'b1 || cd !== 32'd1) begin
            n_err++;
            $display("FAIL msend_done: got trd=%b cd=%0d expected 1/1", trd, cd);
        end
        sbf = 1'b1;
        @(negedge clk);
        sbf = 1'b0;
        n_cmp++;
        if (sd !== 1'b0) begin n_err++; $display("FAIL msend_start_bit: got %b expected 0", sd); end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({sd, trd, send_done, rst, req} !== 5'b10010 || cd !== 32'd0) begin
            n_err++;
            $display("FAIL msend_reset: got sd=%b trd=%b sdn=%b rst=%b req=%b cd=%0d expected 1,0,0,1,0,0",
                     sd, trd, send_done, rst, req, cd);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (sd !== 1'b1 || send_done !== 1'b0) begin
            n_err++;
            $display("FAIL msend_after: got sd=%b sdn=%b expected 1/0", sd, send_done);
        end
    endtask

    initial begin
        test_reset();
        test_ramp_capture();
        test_equality_pol();
        test_first_sample();
        test_gaps_and_ignores();
        test_checksum();
        test_reset_mid_send();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timed out");
    end

endmodule
